// File: rtl/esplink_pkg.sv
// Shared constants and types for the ESP debug-link soft-reset controller.
package esplink_pkg;

  // Register word offsets
  localparam logic [2:0] CMD      = 3'd0;
  localparam logic [2:0] STATUS   = 3'd1;
  localparam logic [2:0] DURATION = 3'd2;
  localparam logic [2:0] ABORT    = 3'd3;
  localparam logic [2:0] ID       = 3'd4;
  localparam logic [2:0] NREG     = 3'd5;

  // Identification word returned from the ID register
  localparam logic [31:0] ESPLINK_SRST_ID = 32'h5352_0002;

  // Decoded register selection
  typedef enum logic [2:0] {
    SEL_CMD,
    SEL_STATUS,
    SEL_DURATION,
    SEL_ABORT,
    SEL_ID,
    SEL_NONE
  } reg_sel_e;

endpackage

// File: rtl/esplink_srst_chan.sv
// One soft-reset channel: pulse counter with abort > trigger > countdown priority.
module esplink_srst_chan
  import esplink_pkg::*;
#(
  parameter int CNT_W = 20
) (
  input  logic             clk,
  input  logic             rstn,
  input  logic             trig,
  input  logic             abort,
  input  logic [CNT_W-1:0] dur,
  output logic             active
);

  logic             active_q, active_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;

  // Next state: abort beats trigger, trigger reloads (retrigger extends), else count down
  always_comb begin
    active_d = active_q;
    cnt_d    = cnt_q;
    if (abort) begin
      active_d = 1'b0;
    end else if (trig) begin
      active_d = 1'b1;
      cnt_d    = dur - CNT_W'(1);
    end else if (active_q) begin
      if (cnt_q == '0) begin
        active_d = 1'b0;
      end else begin
        cnt_d = cnt_q - CNT_W'(1);
      end
    end
  end

  // Channel state register; reset ends any pulse in progress
  always_ff @(posedge clk) begin
    if (!rstn) begin
      active_q <= 1'b0;
      cnt_q    <= '0;
    end else begin
      active_q <= active_d;
      cnt_q    <= cnt_d;
    end
  end

  assign active = active_q;

endmodule

// File: rtl/esplink_srst_mc.sv
// APB slave driving NCH programmable-width soft-reset pulses.
module esplink_srst_mc
  import esplink_pkg::*;
#(
  parameter int APB_DW     = 32,
  parameter int APB_AW     = 32,
  parameter int REV_ENDIAN = 0,
  parameter int NCH        = 4,
  parameter int CNT_W      = 20,
  parameter logic [CNT_W-1:0] DEFAULT_CYCLES = 20'hFFFFF
) (
  input  logic              clk,
  input  logic              rstn,
  input  logic              psel,
  input  logic              penable,
  input  logic              pwrite,
  input  logic [APB_AW-1:0] paddr,
  input  logic [APB_DW-1:0] pwdata,
  output logic              pready,
  output logic              pslverr,
  output logic [APB_DW-1:0] prdata,
  output logic [NCH-1:0]    srst
);

  localparam int LSB = $clog2(APB_DW / 8);

  function automatic logic [APB_DW-1:0] byte_rev(input logic [APB_DW-1:0] d);
    logic [APB_DW-1:0] r;
    r = '0;
    for (int i = 0; i < APB_DW / 8; i++) begin
      r[8*i +: 8] = d[APB_DW-8-8*i +: 8];
    end
    return r;
  endfunction

  logic [APB_DW-1:0] wdata;
  logic [APB_DW-1:0] rdata_raw;
  logic [2:0]        offset;
  reg_sel_e          sel;
  logic              access, err, wr_ok;
  logic [NCH-1:0]    trig, abort, active;
  logic [CNT_W-1:0]  dur_q, dur_d, dur_eff;
  logic              unused_bits;

  assign wdata  = (REV_ENDIAN != 0) ? byte_rev(pwdata) : pwdata;
  assign offset = paddr[LSB+2:LSB];
  assign access = psel & penable;

  // Word offset to register selection
  always_comb begin
    sel = SEL_NONE;
    case (offset)
      CMD:      sel = SEL_CMD;
      STATUS:   sel = SEL_STATUS;
      DURATION: sel = SEL_DURATION;
      ABORT:    sel = SEL_ABORT;
      ID:       sel = SEL_ID;
      default:  sel = SEL_NONE;
    endcase
  end

  // Invalid offsets and writes to read-only registers are rejected without side effects
  assign err   = access & ((sel == SEL_NONE) |
                           (pwrite & ((sel == SEL_STATUS) | (sel == SEL_ID))));
  assign wr_ok = access & pwrite & ~err;

  assign trig  = (wr_ok && sel == SEL_CMD)   ? wdata[NCH-1:0] : '0;
  assign abort = (wr_ok && sel == SEL_ABORT) ? wdata[NCH-1:0] : '0;

  // DURATION next value; only the low CNT_W bits are stored
  always_comb begin
    dur_d = dur_q;
    if (wr_ok && sel == SEL_DURATION) begin
      dur_d = wdata[CNT_W-1:0];
    end
  end

  // DURATION register
  always_ff @(posedge clk) begin
    if (!rstn) begin
      dur_q <= DEFAULT_CYCLES;
    end else begin
      dur_q <= dur_d;
    end
  end

  // A zero duration still produces a single-cycle pulse
  assign dur_eff = (dur_q == '0) ? CNT_W'(1) : dur_q;

  for (genvar g = 0; g < NCH; g++) begin : g_chan
    esplink_srst_chan #(.CNT_W(CNT_W)) u_chan (
      .clk    (clk),
      .rstn   (rstn),
      .trig   (trig[g]),
      .abort  (abort[g]),
      .dur    (dur_eff),
      .active (active[g])
    );
  end

  // Read mux; write-only and erroring accesses return zero
  always_comb begin
    rdata_raw = '0;
    if (!err) begin
      case (sel)
        SEL_STATUS:   rdata_raw[NCH-1:0]   = active;
        SEL_DURATION: rdata_raw[CNT_W-1:0] = dur_q;
        SEL_ID:       rdata_raw            = APB_DW'(ESPLINK_SRST_ID);
        default:      rdata_raw            = '0;
      endcase
    end
  end

  assign prdata  = (REV_ENDIAN != 0) ? byte_rev(rdata_raw) : rdata_raw;
  assign pslverr = err;
  assign pready  = 1'b1;
  assign srst    = active;

  // Address bits outside the word offset and upper data bits carry no meaning here
  assign unused_bits = ^{paddr, wdata};

endmodule

// File: tb/tb_esplink_srst_mc.sv
// Directed bench for esplink_srst_mc: normal and byte-reversed builds plus a bare channel.
module tb_esplink_srst_mc;

  logic        clk = 1'b0;
  logic        rstn = 1'b0;
  logic        psel_m = 1'b0, psel_r = 1'b0;
  logic        penable = 1'b0, pwrite = 1'b0;
  logic [31:0] paddr = '0, pwdata = '0;
  logic        pready_m, pready_r, pslverr_m, pslverr_r;
  logic [31:0] prdata_m, prdata_r;
  logic [3:0]  srst_m, srst_r;

  logic        u_trig = 1'b0, u_abort = 1'b0, u_active;
  logic [19:0] u_dur = 20'd3;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  esplink_srst_mc #(.REV_ENDIAN(0)) dut (
    .clk(clk), .rstn(rstn), .psel(psel_m), .penable(penable), .pwrite(pwrite),
    .paddr(paddr), .pwdata(pwdata), .pready(pready_m), .pslverr(pslverr_m),
    .prdata(prdata_m), .srst(srst_m)
  );

  esplink_srst_mc #(.REV_ENDIAN(1)) dut_rev (
    .clk(clk), .rstn(rstn), .psel(psel_r), .penable(penable), .pwrite(pwrite),
    .paddr(paddr), .pwdata(pwdata), .pready(pready_r), .pslverr(pslverr_r),
    .prdata(prdata_r), .srst(srst_r)
  );

  esplink_srst_chan #(.CNT_W(20)) u_chan (
    .clk(clk), .rstn(rstn), .trig(u_trig), .abort(u_abort), .dur(u_dur), .active(u_active)
  );

  // Pulse monitor: rising-edge counts and the length of the most recent completed pulse
  bit [3:0] prev_m = '0;
  int rises [4] = '{0, 0, 0, 0};
  int run   [4] = '{0, 0, 0, 0};
  int last  [4] = '{0, 0, 0, 0};
  bit prev_r = 1'b0;
  int rises_r = 0, run_r = 0, last_r = 0;

  always @(negedge clk) begin
    for (int c = 0; c < 4; c++) begin
      if (srst_m[c] === 1'b1) begin
        if (!prev_m[c]) begin
          rises[c]++;
          run[c] = 1;
        end else begin
          run[c]++;
        end
      end else if (prev_m[c]) begin
        last[c] = run[c];
      end
      prev_m[c] = (srst_m[c] === 1'b1);
    end
    if (srst_r[0] === 1'b1) begin
      if (!prev_r) begin
        rises_r++;
        run_r = 1;
      end else begin
        run_r++;
      end
    end else if (prev_r) begin
      last_r = run_r;
    end
    prev_r = (srst_r[0] === 1'b1);
  end

  task automatic apb_write(input bit rev, input logic [31:0] addr, input logic [31:0] data,
                           output logic err);
    @(negedge clk);
    psel_m = !rev; psel_r = rev; penable = 1'b0; pwrite = 1'b1;
    paddr = addr; pwdata = data;
    @(negedge clk);
    penable = 1'b1;
    #1;
    err = rev ? pslverr_r : pslverr_m;
    @(posedge clk);
    #1;
    psel_m = 1'b0; psel_r = 1'b0; penable = 1'b0; pwrite = 1'b0;
  endtask

  task automatic apb_read(input bit rev, input logic [31:0] addr,
                          output logic [31:0] data, output logic err);
    @(negedge clk);
    psel_m = !rev; psel_r = rev; penable = 1'b0; pwrite = 1'b0;
    paddr = addr;
    @(negedge clk);
    penable = 1'b1;
    #1;
    data = rev ? prdata_r : prdata_m;
    err  = rev ? pslverr_r : pslverr_m;
    @(posedge clk);
    #1;
    psel_m = 1'b0; psel_r = 1'b0; penable = 1'b0;
  endtask

  task automatic test_reset();
    logic [31:0] d;
    logic        e;
    rstn = 1'b0;
    repeat (3) @(posedge clk);
    #1 rstn = 1'b1;
    checks++;
    if (srst_m !== 4'b0000) begin
      errors++; $display("FAIL reset_srst: got %b want 0000", srst_m);
    end
    checks++;
    if (pslverr_m !== 1'b0 || pready_m !== 1'b1) begin
      errors++; $display("FAIL reset_idle: pslverr %b pready %b want 0 1", pslverr_m, pready_m);
    end
    apb_read(0, 32'h8, d, e);
    checks++;
    if (d !== 32'h000FFFFF || e !== 1'b0) begin
      errors++; $display("FAIL reset_duration: got %h err %b want 000fffff err 0", d, e);
    end
    apb_read(0, 32'h10, d, e);
    checks++;
    if (d !== 32'h53520002 || e !== 1'b0) begin
      errors++; $display("FAIL reset_id: got %h err %b want 53520002 err 0", d, e);
    end
    apb_read(0, 32'h4, d, e);
    checks++;
    if (d !== 32'h0) begin
      errors++; $display("FAIL reset_status: got %h want 0", d);
    end
  endtask

  task automatic test_pulse();
    logic [31:0] d;
    logic        e;
    int b [4];
    apb_write(0, 32'h8, 32'd5, e);
    for (int c = 0; c < 4; c++) b[c] = rises[c];
    apb_write(0, 32'h0, 32'h1, e);
    apb_read(0, 32'h4, d, e);
    checks++;
    if (d !== 32'h1) begin
      errors++; $display("FAIL pulse_status_mid: got %h want 1", d);
    end
    repeat (10) @(negedge clk);
    checks++;
    if (rises[0] - b[0] != 1 || last[0] != 5) begin
      errors++; $display("FAIL pulse_width: rises %0d len %0d want 1 5", rises[0] - b[0], last[0]);
    end
    checks++;
    if (rises[1] != b[1] || rises[2] != b[2] || rises[3] != b[3]) begin
      errors++; $display("FAIL pulse_other_ch: extra rises %0d %0d %0d want 0",
                         rises[1] - b[1], rises[2] - b[2], rises[3] - b[3]);
    end
    apb_read(0, 32'h4, d, e);
    checks++;
    if (d !== 32'h0) begin
      errors++; $display("FAIL pulse_status_after: got %h want 0", d);
    end
    // CMD bits at or above NCH do nothing
    for (int c = 0; c < 4; c++) b[c] = rises[c];
    apb_write(0, 32'h0, 32'hFFFF_FFF0, e);
    repeat (8) @(negedge clk);
    checks++;
    if (rises[0] != b[0] || rises[1] != b[1] || rises[2] != b[2] || rises[3] != b[3]) begin
      errors++; $display("FAIL cmd_high_bits: srst rose, srst now %b want no rise", srst_m);
    end
  endtask

  task automatic test_retrigger();
    logic e;
    int b;
    apb_write(0, 32'h8, 32'd10, e);
    b = rises[1];
    apb_write(0, 32'h0, 32'h2, e);
    repeat (4) @(negedge clk);
    apb_write(0, 32'h0, 32'h2, e);
    repeat (20) @(negedge clk);
    checks++;
    if (rises[1] - b != 1 || last[1] != 16) begin
      errors++; $display("FAIL retrigger: rises %0d len %0d want 1 16", rises[1] - b, last[1]);
    end
  endtask

  task automatic test_abort();
    logic e;
    int b [4];
    apb_write(0, 32'h8, 32'd100, e);
    for (int c = 0; c < 4; c++) b[c] = rises[c];
    apb_write(0, 32'h0, 32'hA, e);
    @(negedge clk);
    apb_write(0, 32'hC, 32'h2, e);
    repeat (110) @(negedge clk);
    checks++;
    if (rises[1] - b[1] != 1 || last[1] != 3) begin
      errors++; $display("FAIL abort_ch1: rises %0d len %0d want 1 3", rises[1] - b[1], last[1]);
    end
    checks++;
    if (rises[3] - b[3] != 1 || last[3] != 100) begin
      errors++; $display("FAIL abort_ch3_full: rises %0d len %0d want 1 100", rises[3] - b[3], last[3]);
    end
    checks++;
    if (rises[0] != b[0] || rises[2] != b[2]) begin
      errors++; $display("FAIL abort_idle_ch: unexpected rise ch0 %0d ch2 %0d", rises[0] - b[0], rises[2] - b[2]);
    end
    // Same-edge trigger and abort on a bare channel: abort wins
    @(negedge clk);
    u_trig = 1'b1; u_abort = 1'b1;
    @(negedge clk);
    u_trig = 1'b0; u_abort = 1'b0;
    checks++;
    if (u_active !== 1'b0) begin
      errors++; $display("FAIL trig_abort_same: active %b want 0", u_active);
    end
    u_trig = 1'b1;
    @(negedge clk);
    u_trig = 1'b0;
    checks++;
    if (u_active !== 1'b1) begin
      errors++; $display("FAIL chan_trig: active %b want 1", u_active);
    end
    u_abort = 1'b1;
    @(negedge clk);
    u_abort = 1'b0;
    checks++;
    if (u_active !== 1'b0) begin
      errors++; $display("FAIL chan_abort: active %b want 0", u_active);
    end
  endtask

  task automatic test_errors();
    logic [31:0] d;
    logic        e;
    int b [4];
    apb_write(0, 32'h8, 32'hFFF0_0007, e);
    apb_read(0, 32'h8, d, e);
    checks++;
    if (d !== 32'h7 || e !== 1'b0) begin
      errors++; $display("FAIL dur_upper_bits: got %h err %b want 00000007 err 0", d, e);
    end
    for (int c = 0; c < 4; c++) b[c] = rises[c];
    apb_write(0, 32'h18, 32'hF, e);
    checks++;
    if (e !== 1'b1) begin
      errors++; $display("FAIL err_wr_ofs6: pslverr %b want 1", e);
    end
    apb_write(0, 32'h4, 32'hF, e);
    checks++;
    if (e !== 1'b1) begin
      errors++; $display("FAIL err_wr_status: pslverr %b want 1", e);
    end
    apb_write(0, 32'h10, 32'hF, e);
    checks++;
    if (e !== 1'b1) begin
      errors++; $display("FAIL err_wr_id: pslverr %b want 1", e);
    end
    apb_read(0, 32'h1C, d, e);
    checks++;
    if (e !== 1'b1 || d !== 32'h0) begin
      errors++; $display("FAIL err_rd_ofs7: got %h err %b want 00000000 err 1", d, e);
    end
    apb_read(0, 32'h0, d, e);
    checks++;
    if (e !== 1'b0 || d !== 32'h0) begin
      errors++; $display("FAIL rd_cmd_zero: got %h err %b want 00000000 err 0", d, e);
    end
    apb_read(0, 32'h8, d, e);
    checks++;
    if (d !== 32'h7) begin
      errors++; $display("FAIL err_no_dur_change: got %h want 00000007", d);
    end
    repeat (4) @(negedge clk);
    checks++;
    if (rises[0] != b[0] || rises[1] != b[1] || rises[2] != b[2] || rises[3] != b[3]) begin
      errors++; $display("FAIL err_no_srst: srst %b rose, want no rise", srst_m);
    end
  endtask

  task automatic test_back_to_back();
    logic e;
    int b [4];
    apb_write(0, 32'h8, 32'd3, e);
    for (int c = 0; c < 4; c++) b[c] = rises[c];
    apb_write(0, 32'h0, 32'hF, e);
    repeat (6) @(negedge clk);
    checks++;
    if (rises[0] - b[0] != 1 || rises[3] - b[3] != 1 || last[0] != 3 || last[1] != 3 ||
        last[2] != 3 || last[3] != 3) begin
      errors++; $display("FAIL multi_start: lens %0d %0d %0d %0d want 3 3 3 3",
                         last[0], last[1], last[2], last[3]);
    end
  endtask

  task automatic test_dur_zero_and_reset();
    logic [31:0] d;
    logic        e;
    int b;
    apb_write(0, 32'h8, 32'd0, e);
    b = rises[0];
    apb_write(0, 32'h0, 32'h1, e);
    repeat (4) @(negedge clk);
    checks++;
    if (rises[0] - b != 1 || last[0] != 1) begin
      errors++; $display("FAIL dur_zero: rises %0d len %0d want 1 1", rises[0] - b, last[0]);
    end
    apb_write(0, 32'h8, 32'd50, e);
    apb_write(0, 32'h0, 32'h1, e);
    repeat (5) @(negedge clk);
    rstn = 1'b0;
    @(negedge clk);
    checks++;
    if (srst_m !== 4'b0000) begin
      errors++; $display("FAIL reset_mid_srst: got %b want 0000", srst_m);
    end
    rstn = 1'b1;
    repeat (2) @(negedge clk);
    checks++;
    if (last[0] != 5) begin
      errors++; $display("FAIL reset_mid_len: len %0d want 5", last[0]);
    end
    apb_read(0, 32'h8, d, e);
    checks++;
    if (d !== 32'h000FFFFF) begin
      errors++; $display("FAIL reset_mid_dur: got %h want 000fffff", d);
    end
  endtask

  task automatic test_rev_endian();
    logic [31:0] d;
    logic        e;
    int b;
    apb_read(1, 32'h10, d, e);
    checks++;
    if (d !== 32'h02005253) begin
      errors++; $display("FAIL rev_id: got %h want 02005253", d);
    end
    apb_write(1, 32'h8, 32'h0500_0000, e);
    apb_read(1, 32'h8, d, e);
    checks++;
    if (d !== 32'h0500_0000 || e !== 1'b0) begin
      errors++; $display("FAIL rev_dur: got %h err %b want 05000000 err 0", d, e);
    end
    b = rises_r;
    apb_write(1, 32'h0, 32'h0100_0000, e);
    repeat (10) @(negedge clk);
    checks++;
    if (rises_r - b != 1 || last_r != 5) begin
      errors++; $display("FAIL rev_pulse: rises %0d len %0d want 1 5", rises_r - b, last_r);
    end
  endtask

  initial begin
    test_reset();
    test_pulse();
    test_retrigger();
    test_abort();
    test_errors();
    test_back_to_back();
    test_dur_zero_and_reset();
    test_rev_endian();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/esplink_srst_mc.md
Name: esplink_srst_mc

Overview:
APB-slave soft-reset controller for the ESP debug link, multi-channel.
- Drives NCH independent soft-reset outputs. Each pulse width is set by a register, not fixed.
- Channels can be retriggered to extend a pulse, or aborted early.
- A pending status bit is readable per channel.
- Sits on the APB link from the host debug interface; srst outputs go to tile/accelerator reset trees.

Parameters:
APB_DW, 32, APB data width (multiple of 8)
APB_AW, 32, APB address width
REV_ENDIAN, 0, 1 = byte-reverse pwdata in and prdata out
NCH, 4, number of reset channels (1..APB_DW)
CNT_W, 20, duration counter width (1..APB_DW)
DEFAULT_CYCLES, 20'hFFFFF, DURATION reset value (must fit in CNT_W)

Ports:
clk  in  1  clock; all logic on rising edge
rstn  in  1  synchronous active-low reset
psel  in  1  APB select
penable  in  1  APB enable
pwrite  in  1  APB write
paddr  in  APB_AW  APB byte address
pwdata  in  APB_DW  APB write data
pready  out  1  constant 1
pslverr  out  1  access error (combinational in access phase)
prdata  out  APB_DW  read data (combinational)
srst  out  NCH  per-channel soft reset, active high

Behaviour:
- Access: access = psel & penable. pready = 1 (zero wait states). Word offset = paddr[LSB+2:LSB], with LSB = log2(APB_DW/8).
- Register map (word offsets):
  - 0 CMD: write-only. Bit i = 1 triggers channel i. Reads return 0.
  - 1 STATUS: read-only. Bit i = active[i]. Upper bits read 0.
  - 2 DURATION: read/write, CNT_W bits. Upper bits ignored on write, read 0.
  - 3 ABORT: write-only. Bit i = 1 deasserts channel i. Reads return 0.
  - 4 ID: read-only constant ESPLINK_SRST_ID from the package.
  - 5-7: invalid.
- pslverr = access & (offset ≥ 5, or write to STATUS/ID). On error: no state change, prdata = 0.
- Endianness: with REV_ENDIAN = 1, bytes are reversed before decode (writes) and after mux (reads).
- Effective duration: D = DURATION, or 1 if DURATION == 0.
- Per-channel state: active[i] (1 bit), cnt[i] (CNT_W bits). srst[i] = active[i], a register output.
- Trigger: a valid CMD write with bit i set, sampled at edge k, gives active[i] <= 1 and cnt[i] <= D-1.
  - srst[i] is high from edge k for exactly D cycles, then low.
- Countdown when active and no trigger/abort this cycle:
  - cnt == 0: active <= 0.
  - otherwise cnt <= cnt - 1.
- Retrigger while active: reload cnt with D-1, extending the pulse. No glitch low.
- ABORT bit i: active[i] <= 0 at next edge. Abort wins over a trigger or countdown in the same cycle. Aborting an idle channel has no effect.
- Multiple CMD bits set: all those channels start on the same edge.
- DURATION write: affects only triggers issued after the write edge. Running counters are unchanged.
- Bits of CMD/ABORT at position ≥ NCH are ignored.
- Reset (rstn = 0 at edge):
  - active = 0, cnt = 0, so srst = 0.
  - DURATION = DEFAULT_CYCLES.
  - Reset mid-pulse terminates the pulse at that edge.
- An srst output never feeds back into this block's own reset.

Decomposition:
- Package esplink_pkg:
  - register offset localparams: CMD = 0, STATUS = 1, DURATION = 2, ABORT = 3, ID = 4, NREG = 5
  - ESPLINK_SRST_ID constant (32'h5352_0002)
  - enum typedef for the decoded register selection
- Sub-module esplink_srst_chan:
  - inputs: clk, rstn, trig, abort, dur (CNT_W bits)
  - output: active
  - contains one counter plus the priority logic
  - instantiated NCH times in a generate loop

Test Plan:
1. Reset, then read DURATION and ID -> prdata = 32'h000FFFFF and 32'h53520002; srst = 0; pslverr = 0.
2. Write DURATION = 5, then CMD = 4'b0001 -> srst[0] high exactly 5 cycles starting after the write edge; srst[3:1] = 0; STATUS reads 1 during the pulse and 0 after.
3. DURATION = 10, trigger ch1, retrigger ch1 after 6 cycles -> srst[1] continuously high for 16 cycles total.
4. DURATION = 100, CMD = 4'b1010, ABORT = 4'b0010 at cycle 3 -> srst[1] falls at that edge; srst[3] stays high for the full 100 cycles. Same-cycle CMD + ABORT on ch2 -> srst[2] never rises.
5. Write to offset 6 and to STATUS; read offset 7 -> pslverr = 1 each time; prdata = 0; no register or srst change.
6. DURATION = 0 with trigger -> 1-cycle pulse. Reset asserted mid-pulse -> srst = 0 after that edge and DURATION back to 32'h000FFFFF. REV_ENDIAN = 1 build: write DURATION with 32'h05000000 -> reads back 32'h05000000, and a subsequent trigger gives a 5-cycle pulse.
